// File: rtl/alu_seq.sv
// Registered, handshaked ALU with a persistent N/Z/C/B/V flag register.
// MUL (shift-add) and ROTN (one bit per cycle) iterate in EXEC; everything else completes in one edge.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operacao,
  input  logic [WIDTH-1:0] operA,
  input  logic [WIDTH-1:0] operB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             B,
  output logic             V,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0] OP_ADIC = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OU   = 4'b0011;
  localparam logic [3:0] OP_E    = 4'b0100;
  localparam logic [3:0] OP_NAO  = 4'b0101;
  localparam logic [3:0] OP_DLE  = 4'b0110;
  localparam logic [3:0] OP_DLD  = 4'b0111;
  localparam logic [3:0] OP_DAE  = 4'b1000;
  localparam logic [3:0] OP_DAD  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_ROTN = 4'b1011;
  localparam logic [3:0] OP_ADC  = 4'b1100;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  wk_hi_q, wk_hi_d;
  logic [WIDTH-1:0]  wk_lo_q, wk_lo_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  result_hi_q, result_hi_d;
  logic              n_q, n_d, z_q, z_d, c_q, c_d, b_q, b_d, v_q, v_d;

  logic              accept;
  logic [WIDTH:0]    add_w, sub_w;
  logic [WIDTH-1:0]  sc_res;
  logic              sc_c, sc_b, sc_v;
  logic [CNTW-1:0]   rot_k;
  logic [2*WIDTH-1:0] mp;
  logic [WIDTH-1:0]  rot_w;

  // Handshake: a request transfers on an edge where in_valid && in_ready; a result
  // transfers on an edge where out_valid && out_ready. Both may happen on the same edge.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_EXEC);
  assign dbg_state = state_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign N = n_q;
  assign Z = z_q;
  assign C = c_q;
  assign B = b_q;
  assign V = v_q;

  // One shift-add step on the {hi,lo} product register; lo starts out holding the multiplier.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo);
    logic [WIDTH:0] s;
    s = {1'b0, hi} + (lo[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
    return {s, lo[WIDTH-1:1]};
  endfunction

  // Single-cycle datapath, also supplies the first rotate step of ROTN.
  always_comb begin
    add_w  = {1'b0, operA} + {1'b0, operB} + {{WIDTH{1'b0}}, (operacao == OP_ADC) & c_q};
    sub_w  = {1'b0, operA} - {1'b0, operB};
    rot_k  = operB[CNTW-1:0];
    sc_res = '0;
    sc_c   = 1'b0;
    sc_b   = 1'b0;
    sc_v   = 1'b0;
    case (operacao)
      OP_ADIC, OP_ADC: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (operA[WIDTH-1] == operB[WIDTH-1]) && (add_w[WIDTH-1] != operA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_b   = sub_w[WIDTH];
        sc_v   = (operA[WIDTH-1] != operB[WIDTH-1]) && (sub_w[WIDTH-1] != operA[WIDTH-1]);
      end
      OP_OU:  sc_res = operA | operB;
      OP_E:   sc_res = operA & operB;
      OP_NAO: sc_res = ~operA;
      OP_DLE: begin sc_res = {operA[WIDTH-2:0], c_q};  sc_c = operA[WIDTH-1]; end
      OP_DLD: begin sc_res = {c_q, operA[WIDTH-1:1]};  sc_c = operA[0];       end
      OP_DAE: begin sc_res = {operA[WIDTH-2:0], 1'b0}; sc_c = operA[WIDTH-1]; end
      OP_DAD: begin sc_res = {1'b0, operA[WIDTH-1:1]}; sc_c = operA[0];       end
      OP_ROTN: begin
        if (rot_k == '0) begin
          sc_res = operA;
        end else begin
          sc_res = {operA[WIDTH-2:0], operA[WIDTH-1]};
          sc_c   = operA[WIDTH-1];
        end
      end
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    wk_hi_d     = wk_hi_q;
    wk_lo_d     = wk_lo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    n_d = n_q; z_d = z_q; c_d = c_q; b_d = b_q; v_d = v_q;
    mp    = mul_step(a_q, wk_hi_q, wk_lo_q);
    rot_w = {wk_lo_q[WIDTH-2:0], wk_lo_q[WIDTH-1]};

    case (state_q)
      S_EXEC: begin
        cnt_d = cnt_q - CNTW'(1);
        if (op_q == OP_MUL) begin
          wk_hi_d = mp[2*WIDTH-1:WIDTH];
          wk_lo_d = mp[WIDTH-1:0];
        end else begin
          wk_lo_d = rot_w;
        end
        if (cnt_q == CNTW'(1)) begin
          state_d = S_DONE;
          b_d = 1'b0;
          v_d = 1'b0;
          if (op_q == OP_MUL) begin
            result_d    = mp[WIDTH-1:0];
            result_hi_d = mp[2*WIDTH-1:WIDTH];
            n_d = mp[2*WIDTH-1];
            z_d = (mp == '0);
            c_d = (mp[2*WIDTH-1:WIDTH] != '0);
          end else begin
            result_d    = rot_w;
            result_hi_d = '0;
            n_d = rot_w[WIDTH-1];
            z_d = (rot_w == '0);
            c_d = wk_lo_q[WIDTH-1];
          end
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: ;
    endcase

    // Accepting overrides the DONE->IDLE retire, giving back-to-back issue.
    if (accept) begin
      op_d = operacao;
      a_d  = operA;
      if (operacao == OP_MUL) begin
        {wk_hi_d, wk_lo_d} = mul_step(operA, '0, operB);
        cnt_d   = CNTW'(WIDTH - 1);
        state_d = S_EXEC;
      end else if ((operacao == OP_ROTN) && (rot_k > CNTW'(1))) begin
        wk_lo_d = sc_res;
        cnt_d   = rot_k - CNTW'(1);
        state_d = S_EXEC;
      end else begin
        state_d     = S_DONE;
        result_d    = sc_res;
        result_hi_d = '0;
        n_d = sc_res[WIDTH-1];
        z_d = (sc_res == '0);
        c_d = sc_c;
        b_d = sc_b;
        v_d = sc_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      wk_hi_q     <= '0;
      wk_lo_q     <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      n_q <= 1'b0; z_q <= 1'b0; c_q <= 1'b0; b_q <= 1'b0; v_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      wk_hi_q     <= wk_hi_d;
      wk_lo_q     <= wk_lo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      n_q <= n_d; z_q <= z_d; c_q <= c_d; b_q <= b_d; v_q <= v_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, handshake/reset sequences, and a
// randomized back-to-back stream scored against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;
  localparam int N_RAND = 60;

  localparam logic [3:0] OP_ADIC = 4'b0001, OP_SUB = 4'b0010, OP_OU = 4'b0011,
                         OP_E = 4'b0100, OP_NAO = 4'b0101, OP_DLE = 4'b0110,
                         OP_DLD = 4'b0111, OP_DAE = 4'b1000, OP_DAD = 4'b1001,
                         OP_MUL = 4'b1010, OP_ROTN = 4'b1011, OP_ADC = 4'b1100;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] operacao;
  logic [W-1:0] operA, operB, result, result_hi;
  logic N, Z, C, B, V;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic m_c;
  logic [2*W+4:0] exp_q[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [4:0]   flags;
    int           lat;
  } vec_t;
  vec_t vecs[21];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operacao(operacao), .operA(operA), .operB(operB), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .N(N), .Z(Z), .C(C), .B(B), .V(V), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sgn(input int unsigned u);
    return (u >= 2**(W-1)) ? int'(u) - 2**W : int'(u);
  endfunction

  // Reference: plain integer arithmetic on the opcode definitions. Returns {hi,res,N,Z,C,B,V}.
  function automatic logic [2*W+4:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
    int unsigned ua, ub, s, p, k;
    int ss;
    logic [W-1:0] res, hi;
    logic n, z, c, bo, v;
    ua = a; ub = b; p = 0;
    res = '0; hi = '0; c = 1'b0; bo = 1'b0; v = 1'b0;
    case (op)
      OP_ADIC, OP_ADC: begin
        s   = ua + ub + ((op == OP_ADC) ? int'(cin) : 0);
        res = W'(s);
        c   = (s >= 2**W);
        ss  = sgn(ua) + sgn(ub) + ((op == OP_ADC) ? int'(cin) : 0);
        v   = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
      end
      OP_SUB: begin
        res = W'(ua - ub);
        bo  = (ua < ub);
        ss  = sgn(ua) - sgn(ub);
        v   = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
      end
      OP_OU:  res = a | b;
      OP_E:   res = a & b;
      OP_NAO: res = ~a;
      OP_DLE: begin res = W'(ua * 2 + int'(cin)); c = (ua >= 2**(W-1)); end
      OP_DLD: begin res = W'(ua / 2 + int'(cin) * 2**(W-1)); c = (ua % 2) == 1; end
      OP_DAE: begin res = W'(ua * 2); c = (ua >= 2**(W-1)); end
      OP_DAD: begin res = W'(ua / 2); c = (ua % 2) == 1; end
      OP_MUL: begin p = ua * ub; res = W'(p); hi = W'(p / 2**W); end
      OP_ROTN: begin
        k = ub % W;
        if (k == 0) res = a;
        else begin
          res = W'((ua << k) | (ua >> (W - k)));
          c   = ((ua >> (W - k)) % 2) == 1;
        end
      end
      default: res = '0;
    endcase
    if (op == OP_MUL) begin
      n = hi[W-1]; z = (p == 0); c = (hi != '0);
    end else begin
      n = res[W-1]; z = (res == '0);
    end
    return {hi, res, n, z, c, bo, v};
  endfunction

  // Issue one op, measure latency and EXEC occupancy, compare, then retire it.
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e_res,
                        input logic [W-1:0] e_hi, input logic [4:0] e_f, input int e_lat);
    int cyc, busy_cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick; cyc++; end
    operacao = op; operA = a; operB = b; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    operacao = 4'($urandom_range(0, 15)); operA = W'($urandom); operB = W'($urandom);
    cyc = 1; busy_cyc = 0;
    while (!out_valid && cyc < 40) begin
      busy_cyc += int'(busy);
      tick;
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(e_lat));
    check({name, "_busy"}, 32'(busy_cyc), 32'(e_lat - 1));
    check({name, "_result"}, 32'({result_hi, result}), 32'({e_hi, e_res}));
    check({name, "_flags"}, 32'({N, Z, C, B, V}), 32'(e_f));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({name, "_retire"}, 32'(out_valid), 32'(0));
    m_c = e_f[2];
  endtask

  initial begin
    int cnt, guard, issued;
    logic acc, ret;
    logic [2*W+4:0] e;

    //               op       A      B      res    hi     NZCBV     lat
    vecs[0]  = '{OP_ADIC, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b10001, 1};
    vecs[1]  = '{OP_SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 5'b10010, 1};
    vecs[2]  = '{OP_OU,   8'h00, 8'h00, 8'h00, 8'h00, 5'b01000, 1};
    vecs[3]  = '{OP_ADIC, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b01100, 1};
    vecs[4]  = '{OP_ADC,  8'h10, 8'h20, 8'h31, 8'h00, 5'b00000, 1};
    vecs[5]  = '{OP_ADIC, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b01100, 1};
    vecs[6]  = '{OP_DLE,  8'h80, 8'h00, 8'h01, 8'h00, 5'b00100, 1};
    vecs[7]  = '{OP_DLD,  8'h01, 8'h00, 8'h80, 8'h00, 5'b10100, 1};
    vecs[8]  = '{OP_DAE,  8'h81, 8'h00, 8'h02, 8'h00, 5'b00100, 1};
    vecs[9]  = '{OP_DAD,  8'h81, 8'h00, 8'h40, 8'h00, 5'b00100, 1};
    vecs[10] = '{OP_E,    8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1};
    vecs[11] = '{OP_NAO,  8'h0F, 8'h00, 8'hF0, 8'h00, 5'b10000, 1};
    vecs[12] = '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b10100, 8};
    vecs[13] = '{OP_ROTN, 8'h81, 8'h03, 8'h0C, 8'h00, 5'b00000, 3};
    vecs[14] = '{OP_ROTN, 8'h81, 8'h00, 8'h81, 8'h00, 5'b10000, 1};
    vecs[15] = '{4'b0000, 8'h55, 8'h33, 8'h00, 8'h00, 5'b01000, 1};
    vecs[16] = '{4'b1111, 8'hAA, 8'h55, 8'h00, 8'h00, 5'b01000, 1};
    vecs[17] = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 5'b00001, 1};
    vecs[18] = '{OP_MUL,  8'h00, 8'h55, 8'h00, 8'h00, 5'b01000, 8};
    vecs[19] = '{OP_ROTN, 8'h01, 8'h07, 8'h80, 8'h00, 5'b10000, 7};
    vecs[20] = '{OP_ADC,  8'hFF, 8'h01, 8'h00, 8'h00, 5'b01100, 1};

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    operacao = '0; operA = '0; operB = '0; m_c = 1'b0;
    tick; tick;
    check("reset_outputs", 32'({out_valid, busy, result_hi, result, N, Z, C, B, V}), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 21; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].hi, vecs[i].flags, vecs[i].lat);

    // Hold a result under backpressure while a different request is offered.
    operacao = OP_ADIC; operA = 8'h7F; operB = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    operacao = OP_NAO; operA = 8'h00; operB = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d", i),
            32'({out_valid, in_ready, busy, result_hi, result, N, Z, C, B, V}),
            32'({1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 5'b10001}));
      tick;
    end
    // Retire and accept on the same edge.
    operacao = OP_SUB; operA = 8'h00; operB = 8'h01; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'(1));
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_result", 32'({out_valid, result, N, Z, C, B, V}),
          32'({1'b1, 8'hFF, 5'b10010}));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Reset in the middle of a multiply.
    operacao = OP_MUL; operA = 8'hFF; operB = 8'hFF; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("mul_busy_before_reset", 32'(busy), 32'(1));
    tick; tick;
    rst_n = 1'b0;
    tick;
    check("midreset_outputs", 32'({out_valid, busy, result_hi, result, N, Z, C, B, V}), 32'(0));
    check("midreset_idle", 32'({in_ready, dbg_state}), 32'({1'b1, 2'b00}));
    rst_n = 1'b1;
    m_c = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cnt += int'(out_valid) + int'(busy);
      tick;
    end
    check("midreset_no_result", 32'(cnt), 32'(0));

    // Randomized stream with random backpressure; back-to-back issue happens naturally.
    issued = 0; guard = 0;
    in_valid = 1'b0;
    while ((issued < N_RAND || exp_q.size() > 0) && guard < 5000) begin
      if (!in_valid && issued < N_RAND && $urandom_range(0, 3) != 0) begin
        operacao = 4'($urandom_range(0, 15));
        operA = W'($urandom);
        operB = W'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        if (exp_q.size() == 0) check("stream_spurious", 32'(1), 32'(0));
        else check("stream", 32'({result_hi, result, N, Z, C, B, V}), 32'(exp_q.pop_front()));
      end
      if (acc) begin
        e = model(operacao, operA, operB, m_c);
        exp_q.push_back(e);
        m_c = e[2];
        issued++;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
      guard++;
    end
    check("stream_drained", 32'(exp_q.size()), 32'(0));
    check("stream_issued", 32'(issued), 32'(N_RAND));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
